serial_addsub_unit: RTL

//  Parametrised bit-serial adder/subtractor with start/busy/done handshake.

---
 rtl/serial_addsub_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/serial_addsub_unit.sv
// serial_addsub_unit: bit-serial adder/subtractor, LSB first, one bit per clock.
// Operands are captured at start, then a single full adder plus a carry
// flip-flop walks across WIDTH bits. Result, carry-out and signed overflow
// are registered and held until the next completion.
module serial_addsub_unit #(
  parameter  int WIDTH = 8,
  localparam int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic {IDLE, SHIFT} state_t;

  // Counter value at which the MSB is being processed.
  localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             bit_s;
  logic             bit_c;

  // State and datapath registers; reset clears everything, aborting any op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: operand capture in IDLE, one full-adder step per SHIFT cycle.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    bit_s = opa_q[0] ^ opb_q[0] ^ carry_q;
    bit_c = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
          opa_d   = A;
          opb_d   = sub ? ~B : B;
          carry_d = sub;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        opa_d   = {1'b0, opa_q[WIDTH-1:1]};
        opb_d   = {1'b0, opb_q[WIDTH-1:1]};
        carry_d = bit_c;
        acc_d   = {bit_s, acc_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNTW'(1);
        if (cnt_q == LAST_BIT) begin
          // On the MSB step carry_q holds the carry into the MSB, so
          // overflow is that carry XOR the carry leaving the MSB.
          sum_d   = {bit_s, acc_q[WIDTH-1:1]};
          cout_d  = bit_c;
          ovf_d   = carry_q ^ bit_c;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
